// File: rtl/vga_frame_sequencer.sv
// Raster timing and test-pattern scheduler for the colour-bar pixel generator.
// Counters, EA and frame_start are registered together; syncs trail the counters by SYNC_DLY clocks.
module vga_frame_sequencer #(
  parameter int H_VISIBLE       = 1024,
  parameter int H_FP            = 24,
  parameter int H_SYNC          = 136,
  parameter int H_BP            = 160,
  parameter int V_VISIBLE       = 768,
  parameter int V_FP            = 3,
  parameter int V_SYNC          = 6,
  parameter int V_BP            = 29,
  parameter int HS_POL          = 0,
  parameter int VS_POL          = 0,
  parameter int SYNC_DLY        = 1,
  parameter int N_MODES         = 4,
  parameter int FRAMES_PER_MODE = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        mode_hold,
  input  logic        mode_next,
  output logic [10:0] count_h,
  output logic [10:0] count_v,
  output logic        EA,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [2:0]  mode
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_VISIBLE + H_FP;
  localparam int HS_END  = H_VISIBLE + H_FP + H_SYNC - 1;
  localparam int VS_BEG  = V_VISIBLE + V_FP;
  localparam int VS_END  = V_VISIBLE + V_FP + V_SYNC - 1;
  localparam int FC_W    = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  logic [11:0]         h_ext, v_ext, h_nxt, v_nxt;
  logic                h_last, v_last, boundary, adv_edge;
  logic                hs_raw, vs_raw;
  logic [SYNC_DLY-1:0] hs_pipe, vs_pipe;
  logic [FC_W-1:0]     frame_cnt;
  logic                pend;

  function automatic logic [2:0] mode_inc(input logic [2:0] m);
    return (m == 3'(N_MODES - 1)) ? 3'd0 : m + 3'd1;
  endfunction

  // 12-bit compare arithmetic keeps porch/sync sums from wrapping
  assign h_ext  = {1'b0, count_h};
  assign v_ext  = {1'b0, count_v};
  assign h_last = (h_ext == 12'(H_TOTAL - 1));
  assign v_last = (v_ext == 12'(V_TOTAL - 1));

  always_comb begin
    h_nxt = h_last ? 12'd0 : h_ext + 12'd1;
    v_nxt = v_ext;
    if (h_last)
      v_nxt = v_last ? 12'd0 : v_ext + 12'd1;
  end

  assign boundary = (h_nxt == 12'd0) && (v_nxt == 12'd0);
  assign adv_edge = en && boundary;
  assign hs_raw   = (h_ext >= 12'(HS_BEG)) && (h_ext <= 12'(HS_END));
  assign vs_raw   = (v_ext >= 12'(VS_BEG)) && (v_ext <= 12'(VS_END));

  // Raster stage: counters, EA, frame_start and sync delay line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_h     <= 11'(H_TOTAL - 1);
      count_v     <= 11'(V_TOTAL - 1);
      EA          <= 1'b0;
      frame_start <= 1'b0;
      hs_pipe     <= '0;
      vs_pipe     <= '0;
    end else if (!en) begin
      count_h     <= 11'(H_TOTAL - 1);
      count_v     <= 11'(V_TOTAL - 1);
      EA          <= 1'b0;
      frame_start <= 1'b0;
      hs_pipe     <= '0;
      vs_pipe     <= '0;
    end else begin
      count_h     <= h_nxt[10:0];
      count_v     <= v_nxt[10:0];
      EA          <= (h_nxt < 12'(H_VISIBLE)) && (v_nxt < 12'(V_VISIBLE));
      frame_start <= boundary;
      hs_pipe[0]  <= hs_raw;
      vs_pipe[0]  <= vs_raw;
      for (int i = 1; i < SYNC_DLY; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
      end
    end
  end

  assign hsync = hs_pipe[SYNC_DLY-1] ? HS_ACT : ~HS_ACT;
  assign vsync = vs_pipe[SYNC_DLY-1] ? VS_ACT : ~VS_ACT;

  // Mode scheduler: survives en=0, only async reset clears it.
  // A request arriving on the boundary edge itself stays pending for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode      <= 3'd0;
      frame_cnt <= '0;
      pend      <= 1'b0;
    end else begin
      if (mode_next)
        pend <= 1'b1;
      else if (adv_edge)
        pend <= 1'b0;
      if (adv_edge) begin
        if (pend) begin
          mode      <= mode_inc(mode);
          frame_cnt <= '0;
        end else if (!mode_hold) begin
          if (frame_cnt == FC_W'(FRAMES_PER_MODE - 1)) begin
            mode      <= mode_inc(mode);
            frame_cnt <= '0;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Bench for vga_frame_sequencer: small-parameter instance against a pixel-index model,
// plus a default-parameter instance checked over its first two lines.
`timescale 1ns/1ps
module tb_vga_frame_sequencer;

  localparam int SHV = 8, SHF = 1, SHS = 2, SHB = 1;
  localparam int SVV = 4, SVF = 1, SVS = 1, SVB = 1;
  localparam int SHT = 12, SVT = 7, SFT = SHT * SVT;
  localparam int SNM = 3, SFPM = 2;
  localparam int DHT = 1344, DVT = 806;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, mode_hold = 1'b0, mode_next = 1'b0;
  logic d_en = 1'b1, d_hold = 1'b0, d_next = 1'b0;

  logic [10:0] s_h, s_v, d_h, d_v;
  logic        s_ea, s_hs, s_vs, s_fs, d_ea, d_hs, d_vs, d_fs;
  logic [2:0]  s_mode, d_mode;

  vga_frame_sequencer #(
    .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .N_MODES(SNM), .FRAMES_PER_MODE(SFPM)
  ) dut_s (
    .clk(clk), .rst(rst), .en(en), .mode_hold(mode_hold), .mode_next(mode_next),
    .count_h(s_h), .count_v(s_v), .EA(s_ea), .hsync(s_hs), .vsync(s_vs),
    .frame_start(s_fs), .mode(s_mode)
  );

  vga_frame_sequencer dut_d (
    .clk(clk), .rst(rst), .en(d_en), .mode_hold(d_hold), .mode_next(d_next),
    .count_h(d_h), .count_v(d_v), .EA(d_ea), .hsync(d_hs), .vsync(d_vs),
    .frame_start(d_fs), .mode(d_mode)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        ea;
    logic        fs;
    logic        hs;
    logic        vs;
    logic [2:0]  mode;
  } exp_t;

  exp_t q_s[$];
  exp_t q_d[$];

  int n_chk = 0, n_fail = 0;

  int m_pix, m_mode, m_fc, t_def;
  bit m_hsd, m_vsd, m_pend, def_on;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pix = SFT - 1; m_hsd = 0; m_vsd = 0;
    m_mode = 0; m_fc = 0; m_pend = 0;
  endtask

  task automatic model_edge(input bit e, input bit hold, input bit nxt);
    int h, v;
    bit at_fs;
    exp_t x;
    h = m_pix % SHT;
    v = m_pix / SHT;
    at_fs = 0;
    if (!e) begin
      m_pix = SFT - 1; m_hsd = 0; m_vsd = 0;
    end else begin
      m_hsd = (h >= SHV + SHF) && (h < SHV + SHF + SHS);
      m_vsd = (v >= SVV + SVF) && (v < SVV + SVF + SVS);
      m_pix = (m_pix + 1) % SFT;
      at_fs = (m_pix == 0);
    end
    if (at_fs) begin
      if (m_pend) begin
        m_mode = (m_mode + 1) % SNM; m_fc = 0;
      end else if (!hold) begin
        m_fc++;
        if (m_fc == SFPM) begin m_fc = 0; m_mode = (m_mode + 1) % SNM; end
      end
    end
    m_pend = nxt | (m_pend & !at_fs);
    h = m_pix % SHT;
    v = m_pix / SHT;
    x.h = 11'(h); x.v = 11'(v);
    x.ea = (h < SHV) && (v < SVV);
    x.fs = at_fs;
    x.hs = !m_hsd; x.vs = !m_vsd;
    x.mode = 3'(m_mode);
    q_s.push_back(x);
  endtask

  task automatic model_def_edge();
    int h, v, ph;
    exp_t x;
    h  = t_def % DHT;
    v  = t_def / DHT;
    ph = (t_def == 0) ? DHT - 1 : (t_def - 1) % DHT;
    x.h = 11'(h); x.v = 11'(v);
    x.ea = (h < 1024) && (v < 768);
    x.fs = (t_def == 0);
    x.hs = !((ph >= 1048) && (ph <= 1183));
    x.vs = 1'b1;
    x.mode = 3'd0;
    q_d.push_back(x);
    t_def++;
  endtask

  task automatic compare_out();
    exp_t x;
    x = q_s.pop_front();
    chk("s_count_h", s_h, x.h);
    chk("s_count_v", s_v, x.v);
    chk("s_EA", s_ea, x.ea);
    chk("s_frame_start", s_fs, x.fs);
    chk("s_hsync", s_hs, x.hs);
    chk("s_vsync", s_vs, x.vs);
    chk("s_mode", s_mode, x.mode);
    if (q_d.size() > 0) begin
      x = q_d.pop_front();
      chk("d_count_h", d_h, x.h);
      chk("d_count_v", d_v, x.v);
      chk("d_EA", d_ea, x.ea);
      chk("d_frame_start", d_fs, x.fs);
      chk("d_hsync", d_hs, x.hs);
      chk("d_vsync", d_vs, x.vs);
      chk("d_mode", d_mode, x.mode);
    end
  endtask

  // Called at a falling edge; drives inputs, lets one rising edge pass, compares at the next falling edge
  task automatic step(input bit e, input bit hold, input bit nxt);
    en = e; mode_hold = hold; mode_next = nxt;
    @(posedge clk);
    model_edge(e, hold, nxt);
    if (def_on) model_def_edge();
    @(negedge clk);
    compare_out();
  endtask

  task automatic run_to(input int pix, input bit hold);
    int k;
    k = 0;
    while (m_pix != pix && k < 2 * SFT) begin
      step(1'b1, hold, 1'b0);
      k++;
    end
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_s_count_h"}, s_h, SHT - 1);
    chk({tag, "_s_count_v"}, s_v, SVT - 1);
    chk({tag, "_s_EA"}, s_ea, 0);
    chk({tag, "_s_frame_start"}, s_fs, 0);
    chk({tag, "_s_hsync"}, s_hs, 1);
    chk({tag, "_s_vsync"}, s_vs, 1);
    chk({tag, "_s_mode"}, s_mode, 0);
    chk({tag, "_d_count_h"}, d_h, DHT - 1);
    chk({tag, "_d_count_v"}, d_v, DVT - 1);
    chk({tag, "_d_EA"}, d_ea, 0);
    chk({tag, "_d_hsync"}, d_hs, 1);
    chk({tag, "_d_vsync"}, d_vs, 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    def_on = 0; t_def = 0;
    model_reset();
    #12;
    reset_chk("rst");

    @(negedge clk);
    rst = 1'b0;
    def_on = 1;
    // Free run: default instance over two full lines, small instance over many frames
    repeat (2700) step(1'b1, 1'b0, 1'b0);
    def_on = 0;

    // Hold mode over several frames
    repeat (5 * SFT) step(1'b1, 1'b1, 1'b0);

    // Two pulses mid-frame while held: exactly one advance
    run_to(30, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    repeat (10) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    repeat (2 * SFT) step(1'b1, 1'b1, 1'b0);

    // Pulse during the frame_start cycle
    run_to(0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    repeat (2 * SFT) step(1'b1, 1'b1, 1'b0);

    // Pulse on the edge that produces frame_start
    run_to(SFT - 1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    repeat (2 * SFT) step(1'b1, 1'b1, 1'b0);

    repeat (3 * SFT) step(1'b1, 1'b0, 1'b0);

    // Disable inside an hsync window, then inside the vsync window
    run_to(34, 1'b1);
    repeat (5) step(1'b0, 1'b1, 1'b0);
    repeat (SFT + 10) step(1'b1, 1'b1, 1'b0);
    run_to(62, 1'b1);
    repeat (5) step(1'b0, 1'b1, 1'b0);
    repeat (SFT + 10) step(1'b1, 1'b1, 1'b0);

    repeat (3 * SFT) step(1'b1, 1'b0, 1'b0);

    // Asynchronous reset between clock edges
    run_to(50, 1'b0);
    #2 rst = 1'b1;
    #1 reset_chk("async");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3 * SFT) step(1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
